modaddsub_iter: RTL
===================

// Module: modaddsub_iter
// PURPOSE
//  Iterative modular add/subtract: res = (op1 + op2) mod p or (op1 - op2) mod p.
//  One shared WIDTH+2-bit signed datapath, one correction step (+p or -p) per cycle.
//  Start/busy/done handshake, mode select, bounded iteration count, error flag.
//  Feeds the point add/double sequencer in the ECC datapath.
// PARAMETERS
//  WIDTH     256  operand, modulus and result width in bits
//  MAX_ITER  4    max correction steps before err; iteration counter is $clog2(MAX_ITER+1) bits
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      synchronous reset, active high
//  start  in   1      request; accepted only when busy=0
//  mode   in   1      0 = add, 1 = subtract; sampled with start
//  op1    in   WIDTH  operand 1; sampled with start
//  op2    in   WIDTH  operand 2; sampled with start
//  mod    in   WIDTH  modulus p; sampled with start, held internally
//  busy   out  1      high in states OP and RED
//  done   out  1      one-cycle pulse; res/err valid from this cycle on
//  err    out  1      valid with done; held until next accepted start
//  res    out  WIDTH  result in [0,p); held until next done
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active high (rst).
//  - Reset: state=IDLE; busy=0, done=0, err=0, res=0, counter=0.
//  - rst has priority over all inputs: asserted mid-operation, it aborts the operation; no done is produced.
//  - Internal r is WIDTH+2 bits, two's complement. Add: r = op1 + op2. Sub: r = op1 - op2. No wrap-around.
//  - States:
//    IDLE: start=1 -> latch operands into r per mode, latch p, cnt=0, err=0 -> OP.
//    OP: p==0 -> done=1, err=1, res=0 -> IDLE. Else -> RED.
//    RED, checked in order:
//      1. 0 <= r < p -> res=r[WIDTH-1:0], done=1 -> IDLE.
//      2. cnt==MAX_ITER -> done=1, err=1, res=0 -> IDLE.
//      3. r < 0 -> r = r + p, cnt++.
//      4. r >= p -> r = r - p, cnt++.
//  - Latency: start sampled in cycle n -> done high in cycle n+2+k, where k = corrections performed.
//  - Error via the cap: done in cycle n+2+MAX_ITER.
//  - done high -> busy low in the same cycle.
//  - start in the done cycle is accepted. The next done is no earlier than 2 cycles later.
//  - start while busy=1: ignored; no queueing, no effect on the running operation.
//  - mode/op1/op2/mod may change freely after the accepting edge.
//  - Comparisons are signed over WIDTH+2 bits, with p zero-extended.
// CONFIGURATION
//  MODADDSUB_RANGE_CHK_EN
//   - defined: in OP, op1 >= p or op2 >= p (registered copies) -> done=1, err=1, res=0 in cycle n+2.
//     The p==0 check takes precedence with the same response.
//   - undefined: any operand values are accepted and reduced iteratively, subject to MAX_ITER.
// TESTING (WIDTH=8, MAX_ITER=4, start pulsed in cycle n)
//  1. add 200+100, p=251 -> done at n+3, res=49, err=0; busy high in n+1..n+2.
//  2. sub 10-20, p=251 -> done at n+3, res=241, err=0.
//  3. add 5+6, p=251 -> done at n+2, res=11, err=0. A second start in n+2 (sub 6-6) -> done at n+4, res=0.
//  4. p=0, any operands -> done at n+2, err=1, res=0.
//  5. add 255+255, p=3, macro undefined -> done at n+6, err=1, res=0.
//     With macro defined -> done at n+2, err=1.
//  6. Start add 200+100 (p=251), then:
//     - start again in n+1 with 1+1 -> ignored; done at n+3, res=49.
//     - rst in n+1 -> no done; busy=0 and res=0 from n+2.

Source files
------------

// File: rtl/modaddsub_iter.sv
// Iterative modular add/subtract over a shared WIDTH+2-bit signed datapath, one +p/-p step per cycle.
// Optional operand range check when MODADDSUB_RANGE_CHK_EN is defined.
module modaddsub_iter #(
    parameter int WIDTH    = 256,
    parameter int MAX_ITER = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] mod,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, OP, RED} state_t;

    state_t                state_reg;
    logic signed [RW-1:0]  r_reg;
    logic [WIDTH-1:0]      p_reg;
    logic [CW-1:0]         cnt_reg;

    logic signed [RW-1:0]  p_ext;
    logic signed [RW-1:0]  r_init;
    logic                  r_neg;
    logic                  r_in_range;
    logic                  cap_hit;
    logic                  range_bad;

    assign p_ext      = signed'({2'b00, p_reg});
    assign r_init     = mode ? signed'({2'b00, op1}) - signed'({2'b00, op2})
                             : signed'({2'b00, op1}) + signed'({2'b00, op2});
    assign r_neg      = r_reg[RW-1];
    assign r_in_range = !r_neg && (r_reg < p_ext);
    assign cap_hit    = (cnt_reg == CW'(MAX_ITER));

`ifdef MODADDSUB_RANGE_CHK_EN
    logic [WIDTH-1:0] op1_reg;
    logic [WIDTH-1:0] op2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_reg <= '0;
            op2_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            op1_reg <= op1;
            op2_reg <= op2;
        end
    end

    assign range_bad = (op1_reg >= p_reg) || (op2_reg >= p_reg);
`else
    assign range_bad = 1'b0;
`endif

    // OP performs the first reduction step itself so that an in-range
    // result is reported two cycles after start, with done registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            r_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            res       <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        r_reg     <= r_init;
                        p_reg     <= mod;
                        cnt_reg   <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= OP;
                    end
                end
                OP, RED: begin
                    if (state_reg == OP && (p_reg == '0 || range_bad)) begin
                        done      <= 1'b1;
                        err       <= 1'b1;
                        res       <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (r_in_range) begin
                        done      <= 1'b1;
                        res       <= r_reg[WIDTH-1:0];
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cap_hit) begin
                        done      <= 1'b1;
                        err       <= 1'b1;
                        res       <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        r_reg     <= r_neg ? r_reg + p_ext : r_reg - p_ext;
                        cnt_reg   <= cnt_reg + CW'(1);
                        state_reg <= RED;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
